lut_eval: RTL and testbench

LUT_EVAL -- requirements
Module: lut_eval

---
 rtl/lut_eval_pkg.sv | 24 ++
 rtl/lut_word_popcnt.sv | 22 ++
 rtl/lut_eval.sv | 150 +++++++++++++++
 tb/tb_lut_eval.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_eval_pkg.sv
// Shared types and sizing helpers for the LUT evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lut_eval_pkg;

    // Controller states: EMPTY until the first commit, SCAN while statistics
    // are being rebuilt, RUN while lookups are served.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SCAN  = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Number of WORD_W-bit words that make up a 2**n_in-entry truth table.
    function automatic int word_count(input int n_in, input int word_w);
        return (2 ** n_in) / word_w;
    endfunction

    // Word-index width; a single-word table still gets a 1-bit address.
    function automatic int addr_width(input int n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

endpackage

// File: rtl/lut_word_popcnt.sv
// Counts the ones in one truth-table word.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of the input word).
//
// Ports: word - WORD_W-bit slice of the active table; cnt - number of set bits.
module lut_word_popcnt #(
    parameter int WORD_W = 8
) (
    input  logic [WORD_W-1:0]             word,
    output logic [$clog2(WORD_W+1)-1:0]   cnt
);

    localparam int CW = $clog2(WORD_W + 1);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WORD_W; i++) begin
            cnt = cnt + CW'(word[i]);
        end
    end

endmodule

// File: rtl/lut_eval.sv
// Programmable N_IN-input boolean function: shadow/active truth tables, lookup pipe.
// Latency: 1 cycle from accepted in_vec to out_valid/out_bit; one result per cycle.
// Backpressure: in_ready drops while a result is stalled (out_valid && !out_ready) or outside RUN.
//
// Ports: cfg_we/cfg_addr/cfg_wdata write the shadow table one word at a time;
//        cfg_commit copies shadow to active and starts SCAN (busy high).
//        in_valid/in_ready/in_vec request a lookup; out_valid/out_ready/out_bit return it.
//        minterm_cnt/const_flag describe the active table.
// Build option: LUT_EVAL_STATS_EN enables the word-per-cycle popcount scan
//        (minterm_cnt, const_flag); without it SCAN lasts one cycle and both read 0.
module lut_eval
    import lut_eval_pkg::*;
#(
    parameter int N_IN   = 5,
    parameter int WORD_W = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          cfg_we,
    input  logic [addr_width(word_count(N_IN, WORD_W))-1:0] cfg_addr,
    input  logic [WORD_W-1:0]                             cfg_wdata,
    input  logic                                          cfg_commit,
    output logic                                          busy,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [N_IN-1:0]                               in_vec,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          out_bit,
    output logic [N_IN:0]                                 minterm_cnt,
    output logic                                          const_flag
);

    localparam int N_WORDS = word_count(N_IN, WORD_W);
    localparam int AW      = addr_width(N_WORDS);
    localparam int TBL     = 2 ** N_IN;

    state_t           state;
    logic [TBL-1:0]   shadow;
    logic [TBL-1:0]   shadow_nxt;
    logic [TBL-1:0]   active;
    logic             accept;
    logic             scan_done;

    assign busy     = (state == SCAN);
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Shadow with this cycle's write applied, so a commit in the same cycle
    // picks up the word being written. Writes are dropped during SCAN.
    always_comb begin
        shadow_nxt = shadow;
        if (cfg_we && (state != SCAN) && (int'(cfg_addr) < N_WORDS)) begin
            shadow_nxt[int'(cfg_addr)*WORD_W +: WORD_W] = cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            shadow <= '0;
            active <= '0;
        end else begin
            shadow <= shadow_nxt;
            case (state)
                EMPTY, RUN: begin
                    if (cfg_commit) begin
                        active <= shadow_nxt;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_done) begin
                        state <= RUN;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef LUT_EVAL_STATS_EN
    localparam int PCW = $clog2(WORD_W + 1);

    logic [AW-1:0]     scan_idx;
    logic [N_IN:0]     scan_acc;
    logic [N_IN:0]     scan_sum;
    logic [N_IN:0]     cnt_q;
    logic              const_q;
    logic [WORD_W-1:0] scan_word;
    logic [PCW-1:0]    word_pc;

    always_comb begin
        scan_word = active[int'(scan_idx)*WORD_W +: WORD_W];
    end

    lut_word_popcnt #(
        .WORD_W (WORD_W)
    ) u_popcnt (
        .word (scan_word),
        .cnt  (word_pc)
    );

    assign scan_sum  = scan_acc + (N_IN+1)'(word_pc);
    assign scan_done = (scan_idx == AW'(N_WORDS - 1));

    // Published statistics only change on the SCAN-to-RUN edge; the
    // accumulator is private to the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx <= '0;
            scan_acc <= '0;
            cnt_q    <= '0;
            const_q  <= 1'b0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + AW'(1);
            scan_acc <= scan_sum;
            if (scan_done) begin
                cnt_q   <= scan_sum;
                const_q <= (scan_sum == '0) || (scan_sum == (N_IN+1)'(TBL));
            end
        end else if (cfg_commit) begin
            scan_idx <= '0;
            scan_acc <= '0;
        end
    end

    assign minterm_cnt = cnt_q;
    assign const_flag  = const_q;
`else
    assign scan_done   = 1'b1;
    assign minterm_cnt = '0;
    assign const_flag  = 1'b0;
`endif

    // Result register: loads on accept (using the table active before any
    // same-edge commit), holds under backpressure, clears once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_bit   <= active[in_vec];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_eval.sv
// Directed bench for lut_eval (N_IN=5, WORD_W=8).
// Latency: n/a. Backpressure: exercised via out_ready.
// Expected statistics depend on LUT_EVAL_STATS_EN.
module tb_lut_eval;

`ifdef LUT_EVAL_STATS_EN
    localparam int  SCAN_LEN = 4;
    localparam bit  STATS    = 1'b1;
`else
    localparam int  SCAN_LEN = 1;
    localparam bit  STATS    = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_commit;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic [5:0] minterm_cnt;
    logic       const_flag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lut_eval #(.N_IN(5), .WORD_W(8)) dut (
        .clk (clk), .rst_n (rst_n),
        .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata),
        .cfg_commit (cfg_commit), .busy (busy),
        .in_valid (in_valid), .in_ready (in_ready), .in_vec (in_vec),
        .out_valid (out_valid), .out_ready (out_ready), .out_bit (out_bit),
        .minterm_cnt (minterm_cnt), .const_flag (const_flag)
    );

    // Stimulus drivers (no checking inside).
    task automatic write_word(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
    endtask

    // Counts busy cycles seen at negedges; returns at the first RUN negedge.
    task automatic wait_scan(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (out_bit !== 1'b0) begin fails++; $display("FAIL reset_out_bit got %b want 0", out_bit); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests++; if (minterm_cnt !== 6'd0) begin fails++; $display("FAIL reset_minterm_cnt got %0d want 0", minterm_cnt); end
        tests++; if (const_flag !== 1'b0) begin fails++; $display("FAIL reset_const_flag got %b want 0", const_flag); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL empty_in_ready got %b want 0", in_ready); end
    endtask

    task automatic test_single_minterm();
        int n;
        write_word(2'd0, 8'h01);
        write_word(2'd1, 8'h00);
        write_word(2'd2, 8'h00);
        write_word(2'd3, 8'h00);
        commit();
        wait_scan(n);
        tests++; if (n !== SCAN_LEN) begin fails++; $display("FAIL single_busy_cycles got %0d want %0d", n, SCAN_LEN); end
        tests++; if (minterm_cnt !== (STATS ? 6'd1 : 6'd0)) begin fails++; $display("FAIL single_minterm_cnt got %0d want %0d", minterm_cnt, STATS ? 1 : 0); end
        tests++; if (const_flag !== 1'b0) begin fails++; $display("FAIL single_const_flag got %b want 0", const_flag); end
        out_ready = 1'b1; in_valid = 1'b1; in_vec = 5'd0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_vec = 5'd1;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin fails++; $display("FAIL single_vec0 got v=%b b=%b want v=1 b=1", out_valid, out_bit); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b0) begin fails++; $display("FAIL single_vec1 got v=%b b=%b want v=1 b=0", out_valid, out_bit); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    // Active table: only minterm 0 set.
    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_vec = 5'd0;
        @(posedge clk); #1;
        in_vec = 5'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin fails++; $display("FAIL bp_hold%0d got v=%b b=%b want v=1 b=1", i, out_valid, out_bit); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_vec = 5'd0;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b0) begin fails++; $display("FAIL b2b_vec1 got v=%b b=%b want v=1 b=0", out_valid, out_bit); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin fails++; $display("FAIL b2b_vec0 got v=%b b=%b want v=1 b=1", out_valid, out_bit); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_all_ones();
        int n;
        for (int w = 0; w < 4; w++) write_word(2'(w), 8'hFF);
        commit();
        wait_scan(n);
        tests++; if (n !== SCAN_LEN) begin fails++; $display("FAIL ones_busy_cycles got %0d want %0d", n, SCAN_LEN); end
        tests++; if (minterm_cnt !== (STATS ? 6'd32 : 6'd0)) begin fails++; $display("FAIL ones_minterm_cnt got %0d want %0d", minterm_cnt, STATS ? 32 : 0); end
        tests++; if (const_flag !== STATS) begin fails++; $display("FAIL ones_const_flag got %b want %b", const_flag, STATS); end
        out_ready = 1'b1;
        for (int v = 0; v < 32; v++) begin
            if (v > 0) @(negedge clk);
            in_valid = 1'b1; in_vec = 5'(v);
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ones_in_ready%0d got %b want 1", v, in_ready); end
            if (v > 0) begin
                tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin fails++; $display("FAIL ones_vec%0d got v=%b b=%b want v=1 b=1", v - 1, out_valid, out_bit); end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin fails++; $display("FAIL ones_vec31 got v=%b b=%b want v=1 b=1", out_valid, out_bit); end
    endtask

    // Active table all ones on entry.
    task automatic test_scan_ignore();
        int n;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_vec = 5'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        write_word(2'd0, 8'h0F);
        write_word(2'd1, 8'h00);
        write_word(2'd2, 8'h00);
        write_word(2'd3, 8'h00);
        commit();
        @(negedge clk);
        if (STATS) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_busy got %b want 1", busy); end
        cfg_commit = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 8'hFF;
        @(posedge clk); #1;
        cfg_commit = 1'b0; cfg_we = 1'b0;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_scan_end got busy=%b want 0", busy); end
        tests++; if (minterm_cnt !== (STATS ? 6'd4 : 6'd0)) begin fails++; $display("FAIL ign_minterm_cnt got %0d want %0d", minterm_cnt, STATS ? 4 : 0); end
        tests++; if (const_flag !== 1'b0) begin fails++; $display("FAIL ign_const_flag got %b want 0", const_flag); end
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin fails++; $display("FAIL ign_pending got v=%b b=%b want v=1 b=1", out_valid, out_bit); end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_vec = 5'd31;
        @(negedge clk);
        in_vec = 5'd3;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b0) begin fails++; $display("FAIL ign_vec31 got v=%b b=%b want v=1 b=0", out_valid, out_bit); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin fails++; $display("FAIL ign_vec3 got v=%b b=%b want v=1 b=1", out_valid, out_bit); end
        // Re-commit the shadow: the dropped write must not have landed there.
        commit();
        wait_scan(n);
        tests++; if (minterm_cnt !== (STATS ? 6'd4 : 6'd0)) begin fails++; $display("FAIL ign_shadow_cnt got %0d want %0d", minterm_cnt, STATS ? 4 : 0); end
        in_valid = 1'b1; in_vec = 5'd31;
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b0) begin fails++; $display("FAIL ign_shadow_vec31 got v=%b b=%b want v=1 b=0", out_valid, out_bit); end
    endtask

    // Active table 0x0F,0,0,0 on entry.
    task automatic test_reset_mid_scan();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_vec = 5'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        commit();
        @(negedge clk);
        if (STATS) @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_vec = 5'd0; out_ready = 1'b1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        tests++; if (out_valid !== 1'b0 || out_bit !== 1'b0) begin fails++; $display("FAIL mid_rst_out got v=%b b=%b want v=0 b=0", out_valid, out_bit); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
        tests++; if (minterm_cnt !== 6'd0 || const_flag !== 1'b0) begin fails++; $display("FAIL mid_rst_stats got cnt=%0d c=%b want 0 0", minterm_cnt, const_flag); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL post_rst%0d got rdy=%b v=%b busy=%b want 0 0 0", i, in_ready, out_valid, busy); end
        end
        in_valid = 1'b0;
    endtask

    // Shadow is all zero after reset.
    task automatic test_same_cycle_commit();
        int n;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 8'h80; cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
        wait_scan(n);
        tests++; if (n !== SCAN_LEN) begin fails++; $display("FAIL same_busy_cycles got %0d want %0d", n, SCAN_LEN); end
        tests++; if (minterm_cnt !== (STATS ? 6'd1 : 6'd0)) begin fails++; $display("FAIL same_minterm_cnt got %0d want %0d", minterm_cnt, STATS ? 1 : 0); end
        out_ready = 1'b1; in_valid = 1'b1; in_vec = 5'd31;
        @(negedge clk);
        in_vec = 5'd0;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin fails++; $display("FAIL same_vec31 got v=%b b=%b want v=1 b=1", out_valid, out_bit); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_bit !== 1'b0) begin fails++; $display("FAIL same_vec0 got v=%b b=%b want v=1 b=0", out_valid, out_bit); end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
        test_reset();
        test_single_minterm();
        test_backpressure();
        test_all_ones();
        test_scan_ignore();
        test_reset_mid_scan();
        test_same_cycle_commit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
